// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: binary <-> Gray conversion.
// Functions operate on 32-bit words; callers zero-extend narrower values and
// truncate the result. Zero-extension keeps the low bits exact because the
// Gray bit at the top of a narrow word only XORs with a zero above it.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] gray_of(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Inverse: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] bin_of(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/param_counter_bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH-parametrised (1..32).
// Ports:
//   bin_i  : binary input value
//   gray_o : Gray code of bin_i, bin_i ^ (bin_i >> 1)
module param_counter_bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  import fifo_pkg::*;

  assign gray_o = WIDTH'(gray_of(32'(bin_i)));

endmodule

// File: rtl/param_counter.sv
// Parametrised synchronous modulo-MODULUS counter for FIFO pointers and
// general divider/timer use. Up/down, enable, parallel load (clamped to
// MODULUS-1), wrap or saturate at the bounds, terminal-count pulse, and a
// registered Gray copy of the count.
//
// Gray pointers change by exactly one bit per step only when MODULUS is a
// power of two and SATURATE=0; instances feeding clock-domain crossings must
// use that configuration.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (q <= RESET_VAL)
//   en       : count enable
//   up       : 1 = increment, 0 = decrement (ignored when en=0)
//   load     : parallel load request (beats en)
//   load_val : value to load, clamped to MODULUS-1
//   q        : registered binary count
//   q_gray   : registered Gray code of q
//   tc       : registered terminal-count pulse (wrap or saturate attempt)
//   at_max   : registered, high while q == MODULUS-1
//   at_min   : registered, high while q == 0
module param_counter #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
  parameter int unsigned     SATURATE  = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);
  import fifo_pkg::*;

  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $error("param_counter: WIDTH must be within 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_chk_modulus
    $error("param_counter: MODULUS must be within 2..2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_chk_reset_val
    $error("param_counter: RESET_VAL must be below MODULUS");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable for compares.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_G = WIDTH'(gray_of(32'(RST_V)));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             at_max_q, at_min_q;
  logic [WIDTH:0]   inc_x;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    inc_x = {1'b0, cnt_q} + (WIDTH+1)'(1);
    if (load) begin
      cnt_d = ({1'b0, load_val} >= MOD_X) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (inc_x == MOD_X) begin
          tc_d = 1'b1;
          if (SATURATE == 0) cnt_d = '0;
        end else begin
          cnt_d = inc_x[WIDTH-1:0];
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d = 1'b1;
          if (SATURATE == 0) cnt_d = MAX_V;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Gray and flag outputs derive from next-q so they register with q.
  param_counter_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (cnt_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= RST_V;
      gray_q   <= RST_G;
      tc_q     <= 1'b0;
      at_max_q <= (RST_V == MAX_V);
      at_min_q <= (RST_V == '0);
    end else begin
      cnt_q    <= cnt_d;
      gray_q   <= gray_d;
      tc_q     <= tc_d;
      at_max_q <= (cnt_d == MAX_V);
      at_min_q <= (cnt_d == '0);
    end
  end

  assign q      = cnt_q;
  assign q_gray = gray_q;
  assign tc     = tc_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: WIDTH=2, defaults
  logic rst_a, en_a, up_a, load_a;
  logic [1:0] lv_a, q_a, g_a;
  logic tc_a, mx_a, mn_a;
  // Instance B: WIDTH=4, MODULUS=10
  logic rst_b, en_b, up_b, load_b;
  logic [3:0] lv_b, q_b, g_b;
  logic tc_b, mx_b, mn_b;
  // Instance C: WIDTH=3, SATURATE=1
  logic rst_c, en_c, up_c, load_c;
  logic [2:0] lv_c, q_c, g_c;
  logic tc_c, mx_c, mn_c;
  // Instance D: WIDTH=4, MODULUS=10, RESET_VAL=3
  logic rst_d, en_d, up_d, load_d;
  logic [3:0] lv_d, q_d, g_d;
  logic tc_d, mx_d, mn_d;

  param_counter #(.WIDTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
    .q(q_a), .q_gray(g_a), .tc(tc_a), .at_max(mx_a), .at_min(mn_a));

  param_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .q(q_b), .q_gray(g_b), .tc(tc_b), .at_max(mx_b), .at_min(mn_b));

  param_counter #(.WIDTH(3), .SATURATE(1)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .up(up_c), .load(load_c), .load_val(lv_c),
    .q(q_c), .q_gray(g_c), .tc(tc_c), .at_max(mx_c), .at_min(mn_c));

  param_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .up(up_d), .load(load_d), .load_val(lv_d),
    .q(q_d), .q_gray(g_d), .tc(tc_d), .at_max(mx_d), .at_min(mn_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
    en_a = 1; en_b = 1; en_c = 1; en_d = 1;
    up_a = 1; up_b = 1; up_c = 1; up_d = 1;
    load_a = 0; load_b = 0; load_c = 0; load_d = 0;
    lv_a = 0; lv_b = 0; lv_c = 0; lv_d = 0;
    tick(); tick();
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    en_a = 0; en_b = 0; en_c = 0; en_d = 0;
    n_cmp++; if (q_a !== 2'd0) begin n_fail++; $display("FAIL reset_q_a got %0d want 0", q_a); end
    n_cmp++; if (g_a !== 2'd0) begin n_fail++; $display("FAIL reset_gray_a got %0d want 0", g_a); end
    n_cmp++; if (tc_a !== 1'b0) begin n_fail++; $display("FAIL reset_tc_a got %b want 0", tc_a); end
    n_cmp++; if ({mx_a, mn_a} !== 2'b01) begin n_fail++; $display("FAIL reset_flags_a got %b want 01", {mx_a, mn_a}); end
    n_cmp++; if (q_d !== 4'd3) begin n_fail++; $display("FAIL reset_q_d got %0d want 3", q_d); end
    n_cmp++; if (g_d !== 4'd2) begin n_fail++; $display("FAIL reset_gray_d got %0d want 2", g_d); end
    n_cmp++; if ({mx_d, mn_d} !== 2'b00) begin n_fail++; $display("FAIL reset_flags_d got %b want 00", {mx_d, mn_d}); end
    n_cmp++; if (q_b !== 4'd0 || mn_b !== 1'b1) begin n_fail++; $display("FAIL reset_b got q=%0d at_min=%b want q=0 at_min=1", q_b, mn_b); end
  endtask

  task automatic test_wrap_w2();
    logic [1:0] eq [6];
    logic [1:0] eg [6];
    logic       et [6];
    logic       em [6];
    eq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    eg = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    et = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    em = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    en_a = 1; up_a = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (q_a !== eq[i]) begin n_fail++; $display("FAIL wrap_q[%0d] got %0d want %0d", i, q_a, eq[i]); end
      n_cmp++; if (g_a !== eg[i]) begin n_fail++; $display("FAIL wrap_gray[%0d] got %0d want %0d", i, g_a, eg[i]); end
      n_cmp++; if (tc_a !== et[i]) begin n_fail++; $display("FAIL wrap_tc[%0d] got %b want %b", i, tc_a, et[i]); end
      n_cmp++; if (mx_a !== em[i]) begin n_fail++; $display("FAIL wrap_at_max[%0d] got %b want %b", i, mx_a, em[i]); end
    end
    en_a = 0;
  endtask

  task automatic test_mod10_updown();
    load_b = 1; lv_b = 4'd9; en_b = 0;
    tick();
    load_b = 0;
    n_cmp++; if (q_b !== 4'd9 || mx_b !== 1'b1 || tc_b !== 1'b0) begin n_fail++; $display("FAIL m10_load9 got q=%0d at_max=%b tc=%b want 9 1 0", q_b, mx_b, tc_b); end
    en_b = 1; up_b = 1;
    tick();
    n_cmp++; if (q_b !== 4'd0 || tc_b !== 1'b1 || mn_b !== 1'b1) begin n_fail++; $display("FAIL m10_up_wrap got q=%0d tc=%b at_min=%b want 0 1 1", q_b, tc_b, mn_b); end
    up_b = 0;
    tick();
    n_cmp++; if (q_b !== 4'd9 || tc_b !== 1'b1) begin n_fail++; $display("FAIL m10_down_wrap got q=%0d tc=%b want 9 1", q_b, tc_b); end
    n_cmp++; if (g_b !== 4'd13) begin n_fail++; $display("FAIL m10_gray9 got %0d want 13", g_b); end
    tick();
    n_cmp++; if (q_b !== 4'd8 || tc_b !== 1'b0) begin n_fail++; $display("FAIL m10_down8 got q=%0d tc=%b want 8 0", q_b, tc_b); end
    tick();
    n_cmp++; if (q_b !== 4'd7 || tc_b !== 1'b0) begin n_fail++; $display("FAIL m10_down7 got q=%0d tc=%b want 7 0", q_b, tc_b); end
    en_b = 0;
  endtask

  task automatic test_saturate();
    load_c = 1; lv_c = 3'd7;
    tick();
    load_c = 0; en_c = 1; up_c = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (q_c !== 3'd7 || tc_c !== 1'b1 || mx_c !== 1'b1) begin n_fail++; $display("FAIL sat_up[%0d] got q=%0d tc=%b at_max=%b want 7 1 1", i, q_c, tc_c, mx_c); end
    end
    load_c = 1; lv_c = 3'd0;
    tick();
    load_c = 0; up_c = 0;
    tick();
    n_cmp++; if (q_c !== 3'd0 || tc_c !== 1'b1 || mn_c !== 1'b1) begin n_fail++; $display("FAIL sat_down got q=%0d tc=%b at_min=%b want 0 1 1", q_c, tc_c, mn_c); end
    up_c = 1;
    tick();
    n_cmp++; if (q_c !== 3'd1 || tc_c !== 1'b0) begin n_fail++; $display("FAIL sat_up_from0 got q=%0d tc=%b want 1 0", q_c, tc_c); end
    en_c = 0;
  endtask

  task automatic test_load_priority();
    en_b = 1; up_b = 1; load_b = 1; lv_b = 4'd5;
    tick();
    n_cmp++; if (q_b !== 4'd5 || tc_b !== 1'b0) begin n_fail++; $display("FAIL load5 got q=%0d tc=%b want 5 0", q_b, tc_b); end
    n_cmp++; if (g_b !== 4'd7) begin n_fail++; $display("FAIL load5_gray got %0d want 7", g_b); end
    lv_b = 4'd12;
    tick();
    n_cmp++; if (q_b !== 4'd9 || mx_b !== 1'b1) begin n_fail++; $display("FAIL load_clamp got q=%0d at_max=%b want 9 1", q_b, mx_b); end
    lv_b = 4'd9;
    tick();
    n_cmp++; if (q_b !== 4'd9 || tc_b !== 1'b0) begin n_fail++; $display("FAIL load_beats_wrap got q=%0d tc=%b want 9 0", q_b, tc_b); end
    load_b = 0; en_b = 0;
  endtask

  task automatic test_reset_mid();
    en_d = 1; up_d = 1;
    tick(); tick(); tick();
    n_cmp++; if (q_d !== 4'd6) begin n_fail++; $display("FAIL mid_count got %0d want 6", q_d); end
    rst_d = 1; load_d = 1; lv_d = 4'd8;
    tick();
    rst_d = 0; load_d = 0; en_d = 0;
    n_cmp++; if (q_d !== 4'd3 || tc_d !== 1'b0 || mn_d !== 1'b0) begin n_fail++; $display("FAIL mid_reset got q=%0d tc=%b at_min=%b want 3 0 0", q_d, tc_d, mn_d); end
    n_cmp++; if (g_d !== 4'd2) begin n_fail++; $display("FAIL mid_reset_gray got %0d want 2", g_d); end
  endtask

  task automatic test_enable_gating();
    load_b = 1; lv_b = 4'd6;
    tick();
    load_b = 0; en_b = 0;
    for (int i = 0; i < 4; i++) begin
      up_b = i[0];
      tick();
      n_cmp++; if (q_b !== 4'd6 || g_b !== 4'd5 || tc_b !== 1'b0) begin n_fail++; $display("FAIL gate[%0d] got q=%0d gray=%0d tc=%b want 6 5 0", i, q_b, g_b, tc_b); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_w2();
    test_mod10_updown();
    test_saturate();
    test_load_priority();
    test_reset_mid();
    test_enable_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
